// File: rtl/addsub_serial_ctrl.sv
// Serial WIDTH-bit add/sub sequencer that drives an external 4-bit slice.
// Ports: clk, rst_n, start/op/a/b request; busy/done/result/c_out/overflow;
//        dp_op/dp_a/dp_b/dp_cin to the slice, dp_sum/dp_cout from it.
module addsub_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             dp_op,
    output logic [3:0]       dp_a,
    output logic [3:0]       dp_b,
    output logic             dp_cin,
    input  logic [3:0]       dp_sum,
    input  logic             dp_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             run;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic             b_msb;

    assign run   = (state_q == RUN);
    assign last  = (cnt_q == CW'(NIB - 1));
    assign a_nib = 4'(a_q >> {cnt_q, 2'b00});
    assign b_nib = 4'(b_q >> {cnt_q, 2'b00});
    // Sign of B as the slice actually sees it (inverted for subtract).
    assign b_msb = b_q[WIDTH-1] ^ op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        cnt_q    <= '0;
                        // Subtract needs the +1 of two's complement.
                        carry_q  <= op;
                        result_q <= '0;
                        c_out_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    result_q[4*cnt_q +: 4] <= dp_sum;
                    carry_q <= dp_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        cnt_q   <= '0;
                        c_out_q <= dp_cout;
                        ovf_q   <= (a_q[WIDTH-1] == b_msb) &&
                                   (dp_sum[3] != a_q[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign dp_op    = op_q;
    assign dp_a     = run ? a_nib : 4'h0;
    assign dp_b     = run ? b_nib : 4'h0;
    assign dp_cin   = run ? carry_q : 1'b0;

endmodule
